// File: rtl/mult_seq_pkg.sv
// Shared CPU definitions for the iterative multiplier.
// Holds the operand/counter widths, the MULT/MULTU funct codes (decoded
// upstream into is_signed) and the state type. The start/busy handshake is
// the same one the divide unit uses: start is honoured only while busy=0,
// and the CPU stalls for as long as busy=1.
package mult_seq_pkg;

    localparam int unsigned MULT_WIDTH = 32;
    localparam int unsigned MULT_CNT_W = 5;

    localparam logic [5:0] FUNCT_MULT  = 6'h18;
    localparam logic [5:0] FUNCT_MULTU = 6'h19;

    // The state is the busy flag itself.
    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } mult_state_e;

endpackage

// File: rtl/mult_step.sv
// One radix-2 shift-add iteration.
// Ports:
//   acc        - partial-product accumulator (WIDTH+1 bits, top bit always 0)
//   sr         - shift register: remaining multiplier bits low, product bits high
//   magb       - unsigned magnitude of operand B
//   acc_next_c - accumulator after conditional add and right shift
//   sr_next_c  - shift register after right shift
module mult_step #(
    parameter int unsigned WIDTH = 32
) (
    input  logic [WIDTH:0]   acc,
    input  logic [WIDTH-1:0] sr,
    input  logic [WIDTH-1:0] magb,
    output logic [WIDTH:0]   acc_next_c,
    output logic [WIDTH-1:0] sr_next_c
);

    logic [WIDTH:0] sum_c;

    // Add magB when the current multiplier bit is set, then shift {acc,sr} right.
    always_comb begin
        sum_c      = acc + (sr[0] ? {1'b0, magb} : '0);
        acc_next_c = {1'b0, sum_c[WIDTH:1]};
        sr_next_c  = {sum_c[0], sr[WIDTH-1:1]};
    end

endmodule

// File: rtl/mult_seq.sv
// Iterative MULT/MULTU unit: one product bit per falling edge, 32 iterations,
// shift-add on operand magnitudes with a final sign correction.
// Ports:
//   clk          - clock, all state updates on the falling edge
//   reset        - synchronous active-high reset
//   multiplicand - operand A (rs)
//   multiplier   - operand B (rt)
//   is_signed    - 1 = MULT, 0 = MULTU
//   start        - request, accepted only while busy=0
//   hi, lo       - registered 64-bit product, upper/lower halves
//   busy         - high while iterating
//   done         - one-cycle pulse on the edge hi/lo update
module mult_seq
    import mult_seq_pkg::*;
#(
    parameter int unsigned WIDTH = MULT_WIDTH,
    parameter int unsigned CNT_W = MULT_CNT_W
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] multiplicand,
    input  logic [WIDTH-1:0] multiplier,
    input  logic             is_signed,
    input  logic             start,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo,
    output logic             busy,
    output logic             done
);

    localparam int unsigned PW = 2 * WIDTH;
    localparam logic [CNT_W-1:0] LAST = CNT_W'(WIDTH - 1);

    mult_state_e      state, state_nxt;
    logic [WIDTH:0]   acc, acc_nxt;
    logic [WIDTH-1:0] sr, sr_nxt;
    logic [WIDTH-1:0] magb, magb_nxt;
    logic             neg, neg_nxt;
    logic [CNT_W-1:0] count, count_nxt;
    logic [WIDTH-1:0] hi_nxt, lo_nxt;
    logic             done_nxt;

    logic [WIDTH-1:0] mag_a_c, mag_b_c;
    logic [WIDTH:0]   step_acc_c;
    logic [WIDTH-1:0] step_sr_c;
    logic [PW-1:0]    product_c;

    // Operand magnitudes; the most negative value maps onto itself as unsigned.
    assign mag_a_c = (is_signed & multiplicand[WIDTH-1]) ? (~multiplicand + WIDTH'(1)) : multiplicand;
    assign mag_b_c = (is_signed & multiplier[WIDTH-1])   ? (~multiplier + WIDTH'(1))   : multiplier;

    mult_step #(.WIDTH(WIDTH)) u_step (
        .acc        (acc),
        .sr         (sr),
        .magb       (magb),
        .acc_next_c (step_acc_c),
        .sr_next_c  (step_sr_c)
    );

    // Next-state and datapath update.
    always_comb begin
        state_nxt = state;
        acc_nxt   = acc;
        sr_nxt    = sr;
        magb_nxt  = magb;
        neg_nxt   = neg;
        count_nxt = count;
        hi_nxt    = hi;
        lo_nxt    = lo;
        done_nxt  = 1'b0;
        product_c = '0;
        case (state)
            ST_IDLE: begin
                if (start) begin
                    state_nxt = ST_RUN;
                    acc_nxt   = '0;
                    sr_nxt    = mag_a_c;
                    magb_nxt  = mag_b_c;
                    neg_nxt   = is_signed & (multiplicand[WIDTH-1] ^ multiplier[WIDTH-1]);
                    count_nxt = '0;
                end
            end
            ST_RUN: begin
                acc_nxt   = step_acc_c;
                sr_nxt    = step_sr_c;
                count_nxt = count + CNT_W'(1);
                if (count == LAST) begin
                    state_nxt = ST_IDLE;
                    done_nxt  = 1'b1;
                    product_c = {step_acc_c[WIDTH-1:0], step_sr_c};
                    // Negating zero yields zero, so no sign artefact on a zero operand.
                    if (neg) begin
                        product_c = ~product_c + PW'(1);
                    end
                    hi_nxt = product_c[PW-1:WIDTH];
                    lo_nxt = product_c[WIDTH-1:0];
                end
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    // State and datapath registers, falling edge to match the divide unit.
    always_ff @(negedge clk) begin
        if (reset) begin
            state <= ST_IDLE;
            acc   <= '0;
            sr    <= '0;
            magb  <= '0;
            neg   <= 1'b0;
            count <= '0;
            hi    <= '0;
            lo    <= '0;
            done  <= 1'b0;
        end else begin
            state <= state_nxt;
            acc   <= acc_nxt;
            sr    <= sr_nxt;
            magb  <= magb_nxt;
            neg   <= neg_nxt;
            count <= count_nxt;
            hi    <= hi_nxt;
            lo    <= lo_nxt;
            done  <= done_nxt;
        end
    end

    assign busy = (state == ST_RUN);

endmodule

// File: tb/tb_mult_seq.sv
// Self-checking bench for mult_seq: a latency/handshake model with a direct
// 64-bit multiply, checked every cycle, plus literal expectations.
module tb_mult_seq;

    logic        clk;
    logic        reset;
    logic [31:0] multiplicand;
    logic [31:0] multiplier;
    logic        is_signed;
    logic        start;
    logic [31:0] hi;
    logic [31:0] lo;
    logic        busy;
    logic        done;

    int n_chk  = 0;
    int n_fail = 0;
    bit chk_en = 0;

    // Reference model state
    bit          m_busy = 0;
    bit          m_done = 0;
    logic [31:0] m_hi   = '0;
    logic [31:0] m_lo   = '0;
    int          m_rem  = 0;
    logic [63:0] m_prod = '0;

    mult_seq dut (
        .clk          (clk),
        .reset        (reset),
        .multiplicand (multiplicand),
        .multiplier   (multiplier),
        .is_signed    (is_signed),
        .start        (start),
        .hi           (hi),
        .lo           (lo),
        .busy         (busy),
        .done         (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [63:0] ref_mul(input logic [31:0] a, input logic [31:0] b, input logic s);
        longint sa;
        longint sb;
        if (s) begin
            sa = $signed(a);
            sb = $signed(b);
            return 64'(sa * sb);
        end
        return {32'b0, a} * {32'b0, b};
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
        end
    endtask

    // Model: accept when idle, 32 busy edges, then the result with a done pulse.
    always @(negedge clk) begin
        if (reset) begin
            m_busy = 0;
            m_done = 0;
            m_hi   = '0;
            m_lo   = '0;
            m_rem  = 0;
        end else begin
            m_done = 0;
            if (m_busy) begin
                m_rem--;
                if (m_rem == 0) begin
                    m_busy = 0;
                    m_done = 1;
                    m_hi   = m_prod[63:32];
                    m_lo   = m_prod[31:0];
                end
            end else if (start) begin
                m_busy = 1;
                m_rem  = 32;
                m_prod = ref_mul(multiplicand, multiplier, is_signed);
            end
        end
    end

    // Per-cycle compare, away from the active (falling) edge.
    always @(posedge clk) begin
        if (chk_en) begin
            chk("busy", 64'(busy), 64'(m_busy));
            chk("done", 64'(done), 64'(m_done));
            chk("hilo", {hi, lo}, {m_hi, m_lo});
        end
    end

    function automatic logic [31:0] pick();
        case ($urandom_range(0, 7))
            0: return 32'h0;
            1: return 32'hFFFF_FFFF;
            2: return 32'h8000_0000;
            3: return 32'h1;
            default: return $urandom;
        endcase
    endfunction

    // Issue one operation (called just after a rising edge) and wait for done.
    // Extra start pulses at loop indices x1/x2 land on busy edges N+x1+1, N+x2+1.
    task automatic do_op(input logic [31:0] a, input logic [31:0] b, input logic s,
                         input int x1, input int x2);
        bit ok;
        multiplicand = a;
        multiplier   = b;
        is_signed    = s;
        start        = 1'b1;
        @(posedge clk);
        start        = 1'b0;
        multiplicand = $urandom;
        multiplier   = $urandom;
        is_signed    = 1'($urandom);
        ok = 0;
        for (int i = 0; i < 40; i++) begin
            start = (i == x1 || i == x2) ? 1'b1 : 1'b0;
            if (start) begin
                multiplicand = $urandom;
                multiplier   = $urandom;
            end
            @(posedge clk);
            if (done === 1'b1) begin
                ok = 1;
                break;
            end
        end
        start = 1'b0;
        n_chk++;
        if (!ok) begin
            n_fail++;
            $display("FAIL op_timeout actual=no_done required=done_within_40 at %0t", $time);
        end
    endtask

    task automatic lit(input string name, input logic [63:0] exp);
        chk(name, {hi, lo}, exp);
        chk({name, "_model"}, {m_hi, m_lo}, exp);
    endtask

    initial begin
        reset        = 1'b1;
        start        = 1'b0;
        multiplicand = '0;
        multiplier   = '0;
        is_signed    = 1'b0;
        repeat (2) @(posedge clk);
        chk_en = 1;
        chk("reset_hilo", {hi, lo}, 64'h0);
        chk("reset_busy", 64'(busy), 64'h0);
        reset = 1'b0;

        do_op(32'd7, 32'hFFFF_FFFD, 1'b1, -1, -1);
        lit("signed_basic", 64'hFFFF_FFFF_FFFF_FFEB);
        do_op(32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, -1, -1);
        lit("unsigned_max", 64'hFFFF_FFFE_0000_0001);
        do_op(32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1, -1, -1);
        lit("signed_m1_m1", 64'h0000_0000_0000_0001);
        do_op(32'h8000_0000, 32'h8000_0000, 1'b1, -1, -1);
        lit("most_neg_sq", 64'h4000_0000_0000_0000);
        do_op(32'h8000_0000, 32'h1, 1'b1, -1, -1);
        lit("most_neg_x1", 64'hFFFF_FFFF_8000_0000);

        // Starts while busy are ignored; immediate restart at N+33 is accepted.
        do_op(32'd7, 32'hFFFF_FFFD, 1'b1, 4, 19);
        lit("busy_start_ignored", 64'hFFFF_FFFF_FFFF_FFEB);
        do_op(32'd1000, 32'd3000, 1'b0, -1, -1);
        lit("back_to_back", 64'd3000000);

        // Reset mid-operation at count=10.
        multiplicand = 32'hDEAD_BEEF;
        multiplier   = 32'h1234_5678;
        is_signed    = 1'b0;
        start        = 1'b1;
        @(posedge clk);
        start = 1'b0;
        repeat (10) @(posedge clk);
        reset = 1'b1;
        @(posedge clk);
        chk("midrst_busy", 64'(busy), 64'h0);
        chk("midrst_done", 64'(done), 64'h0);
        chk("midrst_hilo", {hi, lo}, 64'h0);
        reset = 1'b0;
        do_op(32'h1234_5678, 32'h10, 1'b0, -1, -1);
        lit("after_reset", 64'h0000_0001_2345_6780);

        do_op(32'h0, 32'hFFFF_FFFB, 1'b1, -1, -1);
        lit("zero_signed", 64'h0);
        do_op(32'hFFFF_FFFF, 32'h1, 1'b1, -1, -1);
        lit("minus_one", 64'hFFFF_FFFF_FFFF_FFFF);

        // Randomized operations, some with ignored starts while busy.
        for (int k = 0; k < 60; k++) begin
            logic [31:0] a;
            logic [31:0] b;
            logic        s;
            int          x;
            a = pick();
            b = pick();
            s = 1'($urandom);
            x = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 30)) : -1;
            do_op(a, b, s, x, -1);
            chk("rand_direct", {hi, lo}, ref_mul(a, b, s));
            if (($urandom_range(0, 2)) == 0) @(posedge clk);
        end

        repeat (3) @(posedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog actual=timeout required=finish at %0t", $time);
        $fatal(1, "watchdog");
    end

endmodule
